// File: rtl/xor_unit_arbiter_pkg.sv
// Shared definitions for the XOR-unit arbiter.
//   N_REQ  : number of requesters (fixed at 4)
//   W      : operand/result width (fixed at 32, matches the XOR unit)
//   ID_W   : width of a requester index
//   CNT_W  : width of the completed-result counter
// rr_pick() performs the round-robin search used by the arbiter.
package xor_unit_arbiter_pkg;

    localparam int N_REQ = 4;
    localparam int W     = 32;
    localparam int ID_W  = 2;
    localparam int CNT_W = 16;

    typedef struct packed {
        logic            found;
        logic [ID_W-1:0] idx;
    } pick_t;

    // First requester with req set, searching ptr, ptr+1, ... mod N_REQ.
    // The loop walks offsets from the farthest to the nearest so the
    // nearest hit is the last write and therefore the winner.
    function automatic pick_t rr_pick(input logic [N_REQ-1:0] req,
                                      input logic [ID_W-1:0]  ptr);
        pick_t           p;
        logic [ID_W-1:0] idx;
        p = '{found: 1'b0, idx: '0};
        for (int k = N_REQ - 1; k >= 0; k--) begin
            idx = ptr + ID_W'(k);
            if (req[idx]) begin
                p.found = 1'b1;
                p.idx   = idx;
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/xor_unit_arbiter_xor.sv
// Gate-level 32-bit bitwise XOR shared by all requesters.
//   a, b : operands
//   y    : a ^ b, purely combinational
module _32_bits_xor
    import xor_unit_arbiter_pkg::*;
(
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] y
);

    for (genvar i = 0; i < W; i++) begin : g_bit
        xor u_xor (y[i], a[i], b[i]);
    end

endmodule

// File: rtl/xor_unit_arbiter.sv
// Round-robin arbiter feeding a two-stage pipeline around one shared XOR.
//   clk, reset          : rising-edge clock, asynchronous active-high reset
//   req[3:0]            : pending operation per requester
//   a_in/b_in[127:0]    : operands, requester i on bits [32i+31:32i]
//   gnt[3:0]            : one-hot combinational grant (0 when none)
//   res/res_id/res_valid: registered result, owner index, valid
//   res_ready           : consumer accepts the result this cycle
//   op_count[15:0]      : wrapping count of accepted results
module xor_unit_arbiter
    import xor_unit_arbiter_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic [N_REQ-1:0]   req,
    input  logic [N_REQ*W-1:0] a_in,
    input  logic [N_REQ*W-1:0] b_in,
    output logic [N_REQ-1:0]   gnt,
    output logic [W-1:0]       res,
    output logic [ID_W-1:0]    res_id,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [CNT_W-1:0]   op_count
);

    logic [ID_W-1:0] rr_ptr;
    logic            v1;
    logic [W-1:0]    a1;
    logic [W-1:0]    b1;
    logic [ID_W-1:0] id1;
    logic            v2;
    logic [W-1:0]    xor_out;

    logic  adv1;
    logic  adv2;
    logic  grant_fire;
    pick_t pick;

    assign adv2 = !v2 || res_ready;
    assign adv1 = !v1 || adv2;
    assign pick = rr_pick(req, rr_ptr);

    // Gated by reset so gnt reads zero while reset is held, even with req high.
    assign grant_fire = adv1 && pick.found && !reset;

    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        gnt = '0;
        if (grant_fire) gnt[pick.idx] = 1'b1;
    end

    _32_bits_xor u_xor (
        .a (a1),
        .b (b1),
        .y (xor_out)
    );

    // NOTE: state uses non-blocking assignments so every register samples
    // pre-edge values; both stages can then advance in the same cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr <= '0;
            v1     <= 1'b0;
            a1     <= '0;
            b1     <= '0;
            id1    <= '0;
        end else if (adv1) begin
            v1 <= grant_fire;
            if (grant_fire) begin
                a1     <= a_in[W*pick.idx +: W];
                b1     <= b_in[W*pick.idx +: W];
                id1    <= pick.idx;
                rr_ptr <= pick.idx + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            v2     <= 1'b0;
            res    <= '0;
            res_id <= '0;
        end else if (adv2) begin
            v2     <= v1;
            res    <= xor_out;
            res_id <= id1;
        end
    end

    assign res_valid = v2;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)                       op_count <= '0;
        else if (res_valid && res_ready) op_count <= op_count + 1'b1;
    end

endmodule
